// File: rtl/alu_64b.sv
// Registered 64-bit integer ALU for the RV64I execute stage.
// Produces result plus cout, carry, overflow and zero flags one cycle after the inputs.
// The shifter (SLL/SRL/SRA) is present only when ALU_SHIFT_EN is defined. Without it,
// those opcodes behave like undefined opcodes.
module alu_64b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  opcode,
  output logic [63:0] result,
  output logic        cout,
  output logic        carry_flag,
  output logic        overflow_flag,
  output logic        zero_flag
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSll  = 4'b0001;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b1101;
  localparam logic [3:0] OpSlt  = 4'b0010;
  localparam logic [3:0] OpSltu = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpAnd  = 4'b0111;

  logic        sub_path;
  logic [63:0] b_eff;
  logic [64:0] sum;
  logic        add_ovf;
  logic        sub_ovf;
  logic        lt_s;
  logic        lt_u;
  logic [63:0] result_d;
  logic        cout_d;
  logic        carry_d;
  logic        ovf_d;

`ifdef ALU_SHIFT_EN
  logic [5:0]  shamt;
  logic [63:0] sll_res;
  logic [63:0] srl_res;
  logic [63:0] sra_res;
`endif

  // Shared adder; the compares reuse the subtract path to get difference and borrow.
  always_comb begin
    sub_path = (opcode == OpSub) || (opcode == OpSlt) || (opcode == OpSltu);
    b_eff    = sub_path ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {64'd0, sub_path};
    add_ovf  = (a[63] == b[63]) && (sum[63] != a[63]);
    sub_ovf  = (a[63] != b[63]) && (sum[63] != a[63]);
    lt_s     = sum[63] ^ sub_ovf;
    lt_u     = ~sum[64];
  end

`ifdef ALU_SHIFT_EN
  // Barrel shifts use only the low six bits of b.
  always_comb begin
    shamt   = b[5:0];
    sll_res = a << shamt;
    srl_res = a >> shamt;
    sra_res = $unsigned($signed(a) >>> shamt);
  end
`endif

  // Result and flag select; undefined opcodes fall through to all-zero.
  always_comb begin
    result_d = 64'd0;
    cout_d   = 1'b0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    unique case (opcode)
      OpAdd: begin
        result_d = sum[63:0];
        cout_d   = sum[64];
        carry_d  = sum[64];
        ovf_d    = add_ovf;
      end
      OpSub: begin
        result_d = sum[63:0];
        cout_d   = sum[64];
        carry_d  = ~sum[64];
        ovf_d    = sub_ovf;
      end
`ifdef ALU_SHIFT_EN
      OpSll:   result_d = sll_res;
      OpSrl:   result_d = srl_res;
      OpSra:   result_d = sra_res;
`endif
      OpSlt:   result_d = {63'd0, lt_s};
      OpSltu:  result_d = {63'd0, lt_u};
      OpXor:   result_d = a ^ b;
      OpOr:    result_d = a | b;
      OpAnd:   result_d = a & b;
      default: result_d = 64'd0;
    endcase
  end

  // Output registers; reset clears everything, including zero_flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result        <= 64'd0;
      cout          <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b0;
    end else begin
      result        <= result_d;
      cout          <= cout_d;
      carry_flag    <= carry_d;
      overflow_flag <= ovf_d;
      zero_flag     <= (result_d == 64'd0);
    end
  end

endmodule

// File: tb/tb_alu_64b.sv
// Scoreboard bench for alu_64b: stimulus pushes expected responses, monitor pops and compares.
// Shift vectors expect real shifts when ALU_SHIFT_EN is defined, undefined-op behaviour otherwise.
module tb_alu_64b;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  opcode;
  logic [63:0] result;
  logic        cout;
  logic        carry_flag;
  logic        overflow_flag;
  logic        zero_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [63:0] res;
    logic        co;
    logic        cf;
    logic        of;
    logic        zf;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] res;
    logic        co;
    logic        cf;
    logic        of;
    logic        zf;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  alu_64b dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .b             (b),
    .opcode        (opcode),
    .result        (result),
    .cout          (cout),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .zero_flag     (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_all_zero(input string name);
    checks++;
    if (result !== 64'd0 || cout !== 1'b0 || carry_flag !== 1'b0 ||
        overflow_flag !== 1'b0 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s: got res=%h co=%b cf=%b of=%b zf=%b, want all zero", name, result,
               cout, carry_flag, overflow_flag, zero_flag);
    end
  endtask

  task automatic add_vec(input logic [63:0] va, input logic [63:0] vb, input logic [3:0] op,
                         input logic [63:0] res, input logic co, input logic cf,
                         input logic of, input logic zf);
    vec_t v;
    v.a = va; v.b = vb; v.op = op; v.res = res; v.co = co; v.cf = cf; v.of = of; v.zf = zf;
    vecs.push_back(v);
  endtask

  task automatic issue(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    a = v.a;
    b = v.b;
    opcode = v.op;
    e.id = id; e.res = v.res; e.co = v.co; e.cf = v.cf; e.of = v.of; e.zf = v.zf;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d results never appeared, want 0 outstanding", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: the DUT presents a fresh result every cycle, one edge after issue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res || cout !== e.co || carry_flag !== e.cf ||
          overflow_flag !== e.of || zero_flag !== e.zf) begin
        errors++;
        $display("FAIL vec%0d: got res=%h co=%b cf=%b of=%b zf=%b, want res=%h co=%b cf=%b of=%b zf=%b",
                 e.id, result, cout, carry_flag, overflow_flag, zero_flag,
                 e.res, e.co, e.cf, e.of, e.zf);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    a      = '0;
    b      = '0;
    opcode = 4'b0000;

    //      a                      b                      op       result                 co cf of zf
    add_vec(64'd5,                 64'd10,                4'b0000, 64'd15,                0, 0, 0, 0);
    add_vec(64'h7FFFFFFFFFFFFFFF,  64'd1,                 4'b0000, 64'h8000000000000000,  0, 0, 1, 0);
    add_vec(64'd10,                64'd5,                 4'b1000, 64'd5,                 1, 0, 0, 0);
    add_vec(64'd5,                 64'd10,                4'b1000, 64'hFFFFFFFFFFFFFFFB,  0, 1, 0, 0);
    add_vec(64'h8000000000000000,  64'd1,                 4'b1000, 64'h7FFFFFFFFFFFFFFF,  1, 0, 1, 0);
    add_vec(64'd5,                 64'hFFFFFFFFFFFFFFFB,  4'b0000, 64'd0,                 1, 1, 0, 1);
    add_vec(64'hFFFFFFFFFFFFFFFB,  64'd3,                 4'b0010, 64'd1,                 0, 0, 0, 0);
    add_vec(64'd5,                 64'hFFFFFFFFFFFFFFFD,  4'b0010, 64'd0,                 0, 0, 0, 1);
    add_vec(64'h8000000000000000,  64'd1,                 4'b0010, 64'd1,                 0, 0, 0, 0);
    add_vec(64'd1,                 64'hFFFFFFFFFFFFFFFF,  4'b0011, 64'd1,                 0, 0, 0, 0);
    add_vec(64'hFFFFFFFFFFFFFFFF,  64'd1,                 4'b0011, 64'd0,                 0, 0, 0, 1);
    add_vec(64'd7,                 64'd7,                 4'b0011, 64'd0,                 0, 0, 0, 1);
    add_vec(64'hAAAAAAAAAAAAAAAA,  64'h5555555555555555,  4'b0100, 64'hFFFFFFFFFFFFFFFF,  0, 0, 0, 0);
    add_vec(64'h1,                 64'h10,                4'b0110, 64'h11,                0, 0, 0, 0);
    add_vec(64'hF0F0F0F0F0F0F0F0,  64'h0F0F0F0F0F0F0F0F,  4'b0111, 64'd0,                 0, 0, 0, 1);
    add_vec(64'd5,                 64'd10,                4'b1111, 64'd0,                 0, 0, 0, 1);
    add_vec(64'hFFFFFFFFFFFFFFFF,  64'hFFFFFFFFFFFFFFFF,  4'b1001, 64'd0,                 0, 0, 0, 1);
`ifdef ALU_SHIFT_EN
    add_vec(64'd1,                 64'd3,                 4'b0001, 64'd8,                 0, 0, 0, 0);
    add_vec(64'h8000000000000000,  64'd4,                 4'b0101, 64'h0800000000000000,  0, 0, 0, 0);
    add_vec(64'hFFFFFFFFFFFFFFF8,  64'd1,                 4'b1101, 64'hFFFFFFFFFFFFFFFC,  0, 0, 0, 0);
    add_vec(64'h123456789ABCDEF0,  64'h40,                4'b0001, 64'h123456789ABCDEF0,  0, 0, 0, 0);
    add_vec(64'h8000000000000000,  64'hFFFFFFFFFFFFFF3F,  4'b0101, 64'd1,                 0, 0, 0, 0);
`else
    add_vec(64'd1,                 64'd3,                 4'b0001, 64'd0,                 0, 0, 0, 1);
    add_vec(64'h8000000000000000,  64'd4,                 4'b0101, 64'd0,                 0, 0, 0, 1);
    add_vec(64'hFFFFFFFFFFFFFFF8,  64'd1,                 4'b1101, 64'd0,                 0, 0, 0, 1);
`endif

    #2;
    check_all_zero("reset_initial");

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back issue: each result must land exactly one edge later.
    for (int i = 0; i < vecs.size(); i++) issue(vecs[i], i);
    drain("drain_main");

    // Mid-stream reset: the in-flight ADD must be discarded, outputs clear without a clock.
    @(negedge clk);
    a = 64'd5;
    b = 64'd10;
    opcode = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");

    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v.a = 64'd1; v.b = 64'd2; v.op = 4'b0000;
      v.res = 64'd3; v.co = 1'b0; v.cf = 1'b0; v.of = 1'b0; v.zf = 1'b0;
      issue(v, 100);
      v.a = 64'd3; v.b = 64'd3; v.op = 4'b1000;
      v.res = 64'd0; v.co = 1'b1; v.cf = 1'b0; v.of = 1'b0; v.zf = 1'b1;
      issue(v, 101);
    end
    drain("drain_post_reset");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
